hack_cpu_core: RTL
==================

Name: hack_cpu_core

Overview:
- Control and register stage directly upstream of the ALU. It decodes Hack instructions, holds the A, D and PC registers, and drives the ALU x/y/control inputs.
- Consumes ALU out/zr/ng to produce the register writeback, the data-memory write and the jump decision.
- Adds a data-memory read handshake so M operands may take multiple cycles to arrive.
- Sits between instruction ROM / data RAM and the existing ALU block, which it instantiates.

Parameters:
- DATA_W, 16, datapath width; fixed by the Hack ISA, parameterised for readability only.
- ADDR_W, 15, PC and data-address width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- instruction  input  16  current instruction, held stable by fetch until consumed.
- instr_valid  input  1  instruction is valid this cycle.
- pc  output  15  address of the instruction to fetch (registered).
- inM  input  16  data-memory read value.
- inM_valid  input  1  inM is valid this cycle.
- readM  output  1  current C-instruction needs M (a-bit = 1).
- outM  output  16  data-memory write value (ALU out).
- writeM  output  1  data-memory write strobe, asserted for exactly one execute cycle.
- addressM  output  15  data-memory address = A[14:0] (value before this instruction's writeback).
- instr_done  output  1  pulses in every cycle an instruction retires.

Behaviour:
- Bit numbering: 15 = MSB. instruction[15]=0 is an A-instruction; 1 is a C-instruction.
- C-instruction fields:
  - a = [12].
  - ALU control = [11:6], mapped to ALU control bits 5..0 as zx, nx, zy, ny, f, no.
  - dest d1(A)=[5], d2(D)=[4], d3(M)=[3].
  - jump j1(<0)=[2], j2(=0)=[1], j3(>0)=[0].
- ALU inputs: x = D; y = a ? inM : A.
- Reset: A=0, D=0, pc=RESET_PC, state=RUN. writeM=0, readM=0, instr_done=0 in the reset cycle and the cycle after.
- Reset asserted mid-MWAIT abandons the instruction; no register or memory write occurs.
- FSM states are RUN and MWAIT.
  - RUN, instr_valid=0: hold all state; writeM=0; instr_done=0.
  - RUN, A-instruction: A <= {0, instruction[14:0]}; pc <= pc+1; retire.
  - RUN, C-instruction with a=0, or a=1 with inM_valid=1: execute and retire in the same cycle.
  - RUN, C-instruction with a=1 and inM_valid=0: go to MWAIT; readM=1; no state change; writeM=0.
  - MWAIT: readM=1. Stay until inM_valid=1, then execute and retire; next state RUN.
  - readM is combinational from the instruction and stays asserted throughout the wait.
- Execute:
  - A <= alu_out if d1.
  - D <= alu_out if d2.
  - writeM = d3, combinational in the execute cycle only.
  - outM = alu_out; addressM = old A.
- Jump taken = (j1 & ng) | (j2 & zr) | (j3 & ~ng & ~zr).
  - Taken: pc <= old A[14:0], so a jump with d1 uses the pre-write A.
  - Not taken: pc <= pc+1.
- pc increment wraps 0x7FFF -> 0x0000.
- Throughput: 1 instruction/cycle with no M wait. Each inM_valid-low cycle adds one stall cycle.
- A-instructions ignore inM_valid.
- A C-instruction with both a=1 and d3 (e.g. M=M+1) waits for the read, then writes in the same execute cycle.
- Arithmetic is 16-bit two's complement, with overflow discarded inside the ALU.

Decomposition:
- Shared package hack_pkg holds:
  - field position constants (A_BIT, DEST_A/D/M, JMP_LT/EQ/GT, COMP_LSB/MSB);
  - the state enum {RUN, MWAIT};
  - width constants DATA_W / ADDR_W.
- Sub-module: the existing ALU, instantiated unchanged.
- Decode and jump logic stays inline (roughly 150–250 RTL lines total).

Test Plan:
- Reset for 2 cycles -> pc=0, A=0, D=0, writeM=0, readM=0.
- 0x0005 then 0xEC10 (D=A), both valid -> D=0x0005, pc=2, instr_done high for 2 cycles.
- A=100, D=5, then 0xE7C8 (M=D+1) -> same cycle: writeM=1, addressM=100, outM=6; next cycle writeM=0.
- 0xFC10 (D=M) with inM_valid low for 3 cycles, then inM=0x1234 valid -> readM=1 for 4 cycles, pc held, D=0x1234, pc+1.
- A=20, D=0xFFFF, 0xE304 (D;JLT) -> pc=20. Repeat with D=0 -> pc+1. 0xEA87 (0;JMP) -> pc=A.
- pc=0x7FFF executing an A-instruction -> pc=0x0000. Assert reset during MWAIT -> no writeM, pc=0.

Source files
------------

// File: rtl/hack_pkg.sv
// Shared Hack ISA constants: instruction field positions, widths and the
// control FSM state type used by the CPU core.
package hack_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 15;

  localparam int unsigned CINSTR_BIT = 15;
  localparam int unsigned A_BIT      = 12;
  localparam int unsigned COMP_MSB   = 11;
  localparam int unsigned COMP_LSB   = 6;
  localparam int unsigned DEST_A     = 5;
  localparam int unsigned DEST_D     = 4;
  localparam int unsigned DEST_M     = 3;
  localparam int unsigned JMP_LT     = 2;
  localparam int unsigned JMP_EQ     = 1;
  localparam int unsigned JMP_GT     = 0;

  typedef enum logic {
    RUN   = 1'b0,
    MWAIT = 1'b1
  } state_e;

endpackage

// File: rtl/hack_cpu_core_alu.sv
// Hack ALU: zero/negate preprocessing on both operands, add or and,
// optional output negate, plus zero and negative flags.
module hack_alu #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  input  logic         zx_i,
  input  logic         nx_i,
  input  logic         zy_i,
  input  logic         ny_i,
  input  logic         f_i,
  input  logic         no_i,
  output logic [W-1:0] out_o,
  output logic         zr_o,
  output logic         ng_o
);

  logic [W-1:0] x_z, x_n, y_z, y_n, f_out;

  always_comb begin
    x_z   = zx_i ? '0 : x_i;
    x_n   = nx_i ? ~x_z : x_z;
    y_z   = zy_i ? '0 : y_i;
    y_n   = ny_i ? ~y_z : y_z;
    f_out = f_i ? (x_n + y_n) : (x_n & y_n);
    out_o = no_i ? ~f_out : f_out;
    zr_o  = (out_o == '0);
    ng_o  = out_o[W-1];
  end

endmodule

// File: rtl/hack_cpu_core.sv
// Hack CPU control/register stage: decodes instructions, holds A/D/PC,
// drives the ALU and waits on a data-memory read handshake for M operands.
module hack_cpu_core
  import hack_pkg::*;
#(
  parameter int unsigned         DATA_W   = hack_pkg::DATA_W,
  parameter int unsigned         ADDR_W   = hack_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] instruction,
  input  logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  input  logic [DATA_W-1:0] inM,
  input  logic              inM_valid,
  output logic              readM,
  output logic [DATA_W-1:0] outM,
  output logic              writeM,
  output logic [ADDR_W-1:0] addressM,
  output logic              instr_done
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] d_q, d_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              boot_q;

  logic              is_c, a_sel, execute, jump_taken;
  logic [5:0]        ctrl;
  logic [DATA_W-1:0] alu_y, alu_out;
  logic              alu_zr, alu_ng;
  logic [ADDR_W-1:0] pc_inc;

  assign is_c   = instruction[CINSTR_BIT];
  assign a_sel  = instruction[A_BIT];
  assign ctrl   = instruction[COMP_MSB:COMP_LSB];
  assign alu_y  = a_sel ? inM : a_q;
  assign pc_inc = pc_q + 1'b1;

  hack_alu #(
    .W(DATA_W)
  ) u_alu (
    .x_i  (d_q),
    .y_i  (alu_y),
    .zx_i (ctrl[5]),
    .nx_i (ctrl[4]),
    .zy_i (ctrl[3]),
    .ny_i (ctrl[2]),
    .f_i  (ctrl[1]),
    .no_i (ctrl[0]),
    .out_o(alu_out),
    .zr_o (alu_zr),
    .ng_o (alu_ng)
  );

  assign jump_taken = (instruction[JMP_LT] & alu_ng)
                    | (instruction[JMP_EQ] & alu_zr)
                    | (instruction[JMP_GT] & ~alu_ng & ~alu_zr);

  // boot_q keeps the cycle after reset quiet: no reads, writes or retires.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    d_d        = d_q;
    pc_d       = pc_q;
    readM      = 1'b0;
    writeM     = 1'b0;
    instr_done = 1'b0;
    execute    = 1'b0;

    if (!reset && !boot_q) begin
      unique case (state_q)
        RUN: begin
          if (instr_valid) begin
            if (!is_c) begin
              a_d        = DATA_W'(instruction[ADDR_W-1:0]);
              pc_d       = pc_inc;
              instr_done = 1'b1;
            end else begin
              readM = a_sel;
              if (a_sel && !inM_valid) state_d = MWAIT;
              else                     execute = 1'b1;
            end
          end
        end
        MWAIT: begin
          readM = 1'b1;
          if (inM_valid) begin
            execute = 1'b1;
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase

      if (execute) begin
        if (instruction[DEST_A]) a_d = alu_out;
        if (instruction[DEST_D]) d_d = alu_out;
        writeM     = instruction[DEST_M];
        pc_d       = jump_taken ? a_q[ADDR_W-1:0] : pc_inc;
        instr_done = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      a_q     <= '0;
      d_q     <= '0;
      pc_q    <= RESET_PC;
      boot_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      d_q     <= d_d;
      pc_q    <= pc_d;
      boot_q  <= 1'b0;
    end
  end

  assign pc       = pc_q;
  assign outM     = alu_out;
  assign addressM = a_q[ADDR_W-1:0];

endmodule
